// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier dispatcher and its operand FIFO.
package mul_pkg;

  localparam int MUL_LEN   = 32;
  localparam int MUL_TAG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } mul_state_e;

  // Entry layout follows the package defaults; LEN/TAG_W overrides must track them.
  typedef struct packed {
    logic [MUL_LEN-1:0]   multiplicand;
    logic [MUL_LEN-1:0]   multiplier;
    logic [MUL_TAG_W-1:0] tag;
  } fifo_entry_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand FIFO: registered write, head visible the cycle after a push.
module op_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  fifo_entry_t              wdata,
  input  logic                     pop,
  output fifo_entry_t              rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mul_dispatcher.sv
// Feeds queued operand pairs to a shift-add multiplier one job at a time and
// returns each product in a tagged valid/ready slot, with a hang watchdog.
module mul_dispatcher
  import mul_pkg::*;
#(
  parameter int LEN     = MUL_LEN,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = MUL_TAG_W,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_multiplicand,
  input  logic [LEN-1:0]   in_multiplier,
  output logic             mul_start,
  output logic [LEN-1:0]   mul_multiplicand,
  output logic [LEN-1:0]   mul_multiplier,
  input  logic [2*LEN-1:0] mul_product,
  input  logic             mul_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*LEN-1:0] out_product,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int WD = $clog2(TIMEOUT);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and data holds while valid waits.

  mul_state_e         state;
  fifo_entry_t        push_entry;
  fifo_entry_t        head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_fire;
  logic               pop_fire;
  logic [TAG_W-1:0]   in_tag;
  logic [TAG_W-1:0]   job_tag;
  logic [WD-1:0]      wdog;

  assign in_ready  = ~fifo_full;
  assign push_fire = in_valid & in_ready;
  assign pop_fire  = (state == ST_IDLE) & ~fifo_empty & ~out_valid;
  assign busy      = (state != ST_IDLE) | (fifo_count != '0) | out_valid;

  always_comb begin
    push_entry              = '0;
    push_entry.multiplicand = in_multiplicand;
    push_entry.multiplier   = in_multiplier;
    push_entry.tag          = in_tag;
  end

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_fire),
    .wdata (push_entry),
    .pop   (pop_fire),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_tag <= '0;
    end else if (push_fire) begin
      in_tag <= in_tag + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      job_tag          <= '0;
      wdog             <= '0;
      out_valid        <= 1'b0;
      out_product      <= '0;
      out_tag          <= '0;
      out_err          <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop_fire) begin
            mul_multiplicand <= head.multiplicand;
            mul_multiplier   <= head.multiplier;
            job_tag          <= head.tag;
            mul_start        <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mul_start <= 1'b0;
          wdog      <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          wdog <= wdog + 1'b1;
          if (mul_finish) begin
            out_product <= mul_product;
            out_err     <= 1'b0;
            out_tag     <= job_tag;
            out_valid   <= 1'b1;
            state       <= ST_IDLE;
          end else if (wdog == WD'(TIMEOUT - 1)) begin
            // Abort lands exactly TIMEOUT cycles after WAIT was entered.
            out_product <= '0;
            out_err     <= 1'b1;
            out_tag     <= job_tag;
            out_valid   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_dispatcher.sv
// Directed bench for mul_dispatcher driving a behavioural fixed-latency
// multiplier that can be told to hang or to emit a stray finish.
module tb_mul_dispatcher;

  localparam int LEN     = 32;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 5;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LEN-1:0]   in_multiplicand = '0;
  logic [LEN-1:0]   in_multiplier = '0;
  logic             mul_start;
  logic [LEN-1:0]   mul_multiplicand;
  logic [LEN-1:0]   mul_multiplier;
  logic [2*LEN-1:0] mul_product;
  logic             mul_finish;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*LEN-1:0] out_product;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  mul_dispatcher #(
    .LEN(LEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplicand  (in_multiplicand),
    .in_multiplier    (in_multiplier),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_finish       (mul_finish),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .out_tag          (out_tag),
    .out_err          (out_err),
    .busy             (busy)
  );

  // ---------------- multiplier model ----------------
  logic [LEN-1:0] ma, mb;
  int   mcnt;
  logic hang      = 1'b0;
  logic force_fin = 1'b0;
  logic op_drift  = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcnt <= 0;
      ma   <= '0;
      mb   <= '0;
    end else begin
      if (mul_start && !hang) begin
        ma   <= mul_multiplicand;
        mb   <= mul_multiplier;
        mcnt <= LAT;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
      if (mcnt != 0 && (mul_multiplicand !== ma || mul_multiplier !== mb))
        op_drift <= 1'b1;
    end
  end

  assign mul_finish  = (mcnt == 1) | force_fin;
  assign mul_product = 64'(ma) * 64'(mb);

  // ---------------- scoreboard ----------------
  logic [68:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic push(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int n = 0;
    in_valid        = 1'b1;
    in_multiplicand = a;
    in_multiplier   = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_job(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                          input logic [TAG_W-1:0] tag);
    push(a, b);
    exp_q.push_back({1'b0, tag, 64'(a) * 64'(b)});
  endtask

  task automatic take(input logic [63:0] ep, input logic [TAG_W-1:0] et, input logic ee);
    int n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("out_product", out_product, ep);
    chk("out_tag", 64'(out_tag), 64'(et));
    chk("out_err", 64'(out_err), 64'(ee));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_cleared", 64'(out_valid), 64'd0);
  endtask

  task automatic take_next();
    logic [68:0] e;
    e = exp_q.pop_front();
    take(e[63:0], e[67:64], e[68]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int starts;
    int t0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_mul_a", 64'(mul_multiplicand), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Stray finish while idle must not produce a result.
    force_fin = 1'b1;
    @(negedge clk);
    force_fin = 1'b0;
    @(negedge clk);
    chk("stray_finish_valid", 64'(out_valid), 64'd0);
    chk("stray_finish_busy", 64'(busy), 64'd0);

    // Single job 7*6, one start pulse, finish-to-valid latency.
    push(32'd7, 32'd6);
    chk("single_busy", 64'(busy), 64'd1);
    n = 0; starts = 0; t0 = 0;
    while (!out_valid && n < 100) begin
      if (mul_start) begin
        starts++;
        t0 = cyc;
      end
      @(negedge clk);
      n++;
    end
    chk("single_starts", 64'(starts), 64'd1);
    chk("single_latency", 64'(cyc - t0), 64'(LAT + 1));
    take(64'd42, 4'd0, 1'b0);

    // Fill: one job in flight plus four queued, output slot blocked.
    for (int i = 0; i < 5; i++) begin
      push_job(32'(i + 3), 32'(i + 100), 4'(i + 1));
      if (i == 3) chk("fill_ready_after4", 64'(in_ready), 64'd1);
    end
    chk("fill_ready_after5", 64'(in_ready), 64'd0);
    repeat (20) @(negedge clk);
    chk("fill_ready_stalled", 64'(in_ready), 64'd0);
    chk("fill_busy", 64'(busy), 64'd1);
    while (exp_q.size() != 0) take_next();

    // Edge operand values.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    take(64'hFFFF_FFFE_0000_0001, 4'd6, 1'b0);
    push(32'd0, 32'h1234);
    take(64'd0, 4'd7, 1'b0);

    // Jobs 9..16 carry tags 8..15; the 17th wraps to tag 0.
    for (int i = 0; i < 8; i++) begin
      push_job(32'(i * 37 + 1), 32'hDEAD_0000 + 32'(i), 4'(i + 8));
      take_next();
    end
    push_job(32'h0001_0001, 32'h0000_FFFF, 4'd0);
    take_next();

    // Watchdog: multiplier never finishes.
    hang = 1'b1;
    push(32'd9, 32'd9);
    n = 0;
    while (!mul_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_start_seen", 64'(mul_start), 64'd1);
    t0 = cyc;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_latency", 64'(cyc - t0), 64'(TIMEOUT + 1));
    take(64'd0, 4'd1, 1'b1);
    hang = 1'b0;

    // Reset in WAIT with two entries queued.
    push(32'd3, 32'd5);
    push(32'd4, 32'd5);
    push(32'd6, 32'd5);
    @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    chk("pre_reset_valid", 64'(out_valid), 64'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mul_start", 64'(mul_start), 64'd0);
    chk("mid_rst_mul_a", 64'(mul_multiplicand), 64'd0);
    chk("mid_rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_start) starts++;
    end
    chk("post_rst_starts", 64'(starts), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    push(32'd11, 32'd13);
    take(64'd143, 4'd0, 1'b0);

    chk("operands_stable", 64'(op_drift), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
